// File: rtl/led_ctrl_pkg.sv
// Shared widths, event encoding and cursor helper for the LED input front end.
package led_ctrl_pkg;

   localparam int unsigned SEL_W      = 3;
   localparam int unsigned STATE_W    = 10;
   localparam int unsigned TURN_BIT   = 9;
   localparam int unsigned HIST_DEPTH = 3;
   localparam int unsigned HIST_W     = HIST_DEPTH * SEL_W;

   // Resolved action for one cycle after priority between the three buttons.
   typedef enum logic [1:0] {
      EvNone,
      EvCommit,
      EvLeft,
      EvRight
   } event_e;

   // Move the cursor one step; the natural SEL_W-bit wrap gives modulo-8 behaviour.
   function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel,
                                                  input logic              up);
      return up ? sel + SEL_W'(1) : sel - SEL_W'(1);
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button path: 2-flop synchronizer, stability-counter debouncer and
// rising-edge detector producing a single-cycle press pulse.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
      $error("button_debouncer: DEBOUNCE_CYCLES out of range 1..65535");
   end

   if (CNT_W != $clog2(DEBOUNCE_CYCLES + 1)) begin : g_bad_cnt_w
      $error("button_debouncer: CNT_W is derived and must not be overridden");
   end

   // Counter value seen on the edge that completes the stability window.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1_q;
   logic             sync_2_q;
   logic             deb_q;
   logic             deb_prev_q;
   logic [CNT_W-1:0] cnt_q;

   // Two-stage synchronizer for the asynchronous raw input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1_q <= 1'b0;
         sync_2_q <= 1'b0;
      end else begin
         sync_1_q <= btn_raw;
         sync_2_q <= sync_1_q;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else if (sync_2_q == deb_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
         // This edge is the DEBOUNCE_CYCLES-th differing sample.
         deb_q <= sync_2_q;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Remember the previous accepted level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_prev_q <= 1'b0;
      end else begin
         deb_prev_q <= deb_q;
      end
   end

   // Only the rising edge is an event; releases are silent.
   assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/led_input_ctrl.sv
// LED input front end: three debounced buttons drive a wrapping cursor and a
// committed selection history with a turn bit.
module led_input_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               btn_enter,
   output logic [SEL_W-1:0]   led_sel,
   output logic [STATE_W-1:0] state,
   output logic               commit
);

   logic press_left;
   logic press_right;
   logic press_enter;

   logic [SEL_W-1:0]   sel_q;
   logic [STATE_W-1:0] state_q;
   logic               commit_q;
   event_e             ev;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_left (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_left),
      .press   (press_left)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_right (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_right),
      .press   (press_right)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_enter (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_enter),
      .press   (press_enter)
   );

   // Priority resolution: enter wins, simultaneous left+right cancel out.
   always_comb begin
      ev = EvNone;
      if (press_enter) begin
         ev = EvCommit;
      end else if (press_left && !press_right) begin
         ev = EvLeft;
      end else if (press_right && !press_left) begin
         ev = EvRight;
      end
   end

   // Cursor, history/turn register and one-cycle commit pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q    <= '0;
         state_q  <= '0;
         commit_q <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         unique case (ev)
            EvCommit: begin
               // Newest selection enters at the bottom, oldest falls off the top.
               state_q  <= {~state_q[TURN_BIT], state_q[HIST_W-SEL_W-1:0], sel_q};
               commit_q <= 1'b1;
            end
            EvLeft:   sel_q <= sel_step(sel_q, 1'b0);
            EvRight:  sel_q <= sel_step(sel_q, 1'b1);
            default:  ;
         endcase
      end
   end

   assign led_sel = sel_q;
   assign state   = state_q;
   assign commit  = commit_q;

endmodule

// File: tb/tb_led_input_ctrl.sv
// Scoreboard bench for led_input_ctrl with DEBOUNCE_CYCLES = 4.
module tb_led_input_ctrl;

   localparam int unsigned DEB = 4;
   // Input driven on the negedge before edge k; output seen on the negedge after edge k+DEB+2.
   localparam int LAT = DEB + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_enter = 1'b0;
   logic [2:0] led_sel;
   logic [9:0] state;
   logic       commit;

   led_input_ctrl #(
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_enter (btn_enter),
      .led_sel   (led_sel),
      .state     (state),
      .commit    (commit)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int sel;
      int st;
      int com;
      int due;
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: cursor, history of three selections as a base-8 number, turn bit.
   int m_sel  = 0;
   int m_hist = 0;
   int m_turn = 0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_event(input bit l, input bit r, input bit e, input int c);
      if (e) begin
         m_hist = (m_hist * 8 + m_sel) % 512;
         m_turn = 1 - m_turn;
         exp_q.push_back('{m_sel, m_turn * 512 + m_hist, 1, c + LAT});
      end else if (l && !r) begin
         m_sel = (m_sel + 7) % 8;
         exp_q.push_back('{m_sel, m_turn * 512 + m_hist, 0, c + LAT});
      end else if (r && !l) begin
         m_sel = (m_sel + 1) % 8;
         exp_q.push_back('{m_sel, m_turn * 512 + m_hist, 0, c + LAT});
      end
   endtask

   task automatic press(input bit l, input bit r, input bit e, input int hold, input int rel);
      @(negedge clk);
      btn_left  = l;
      btn_right = r;
      btn_enter = e;
      model_event(l, r, e, cyc);
      repeat (hold) @(negedge clk);
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_enter = 1'b0;
      repeat (rel) @(negedge clk);
   endtask

   task automatic glitch(input int which, input int len);
      @(negedge clk);
      if (which == 0) btn_left = 1'b1;
      else if (which == 1) btn_right = 1'b1;
      else btn_enter = 1'b1;
      repeat (len) @(negedge clk);
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_enter = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_sel"}, int'(led_sel), m_sel);
      check({tag, "_state"}, int'(state), m_turn * 512 + m_hist);
      check({tag, "_commit"}, int'(commit), 0);
   endtask

   // Monitor: every visible output change must match the oldest expectation.
   initial begin
      logic [2:0] p_sel;
      logic [9:0] p_state;
      logic       p_commit;
      exp_t       e;
      p_sel    = '0;
      p_state  = '0;
      p_commit = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_sel    = led_sel;
            p_state  = state;
            p_commit = commit;
         end else begin
            if (commit) check("commit_width", int'(p_commit), 0);
            if (led_sel != p_sel || state != p_state) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_update: got sel=%0d state=0x%0h required no change",
                           led_sel, state);
               end else begin
                  e = exp_q.pop_front();
                  check("sel", int'(led_sel), e.sel);
                  check("state", int'(state), e.st);
                  check("commit", int'(commit), e.com);
                  check("latency", cyc, e.due);
               end
            end else begin
               if (commit) check("commit_no_update", int'(commit), 0);
               if (exp_q.size() != 0 && cyc > exp_q[0].due + 1) begin
                  e = exp_q.pop_front();
                  n_tests++;
                  n_fail++;
                  $display("FAIL missing_update: got sel=%0d state=0x%0h required sel=%0d state=0x%0h",
                           led_sel, state, e.sel, e.st);
               end
            end
            p_sel    = led_sel;
            p_state  = state;
            p_commit = commit;
         end
      end
   end

   // Hard stop if the stimulus ever stalls.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int w;
      // Reset and idle.
      repeat (3) @(negedge clk);
      check_idle("in_reset");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_idle("idle");

      // Eight right presses walk the cursor around once.
      for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 1'b0, 30, 30);
      check_idle("right_walk");

      // Left wraps 0 -> 7, short glitch is ignored.
      press(1'b1, 1'b0, 1'b0, 20, 20);
      check_idle("left_wrap");
      glitch(1, 3);
      check_idle("glitch");

      // Cursor to 5, commit: state becomes 0x205.
      press(1'b1, 1'b0, 1'b0, 15, 15);
      press(1'b1, 1'b0, 1'b0, 15, 15);
      press(1'b0, 1'b0, 1'b1, 15, 15);
      check_idle("commit_5");

      // Reset mid-debounce with enter held.
      @(negedge clk);
      btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_sel", int'(led_sel), 0);
      check("rst_state", int'(state), 0);
      check("rst_commit", int'(commit), 0);
      exp_q.delete();
      m_sel  = 0;
      m_hist = 0;
      m_turn = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_event(1'b0, 1'b0, 1'b1, cyc);
      repeat (20) @(negedge clk);
      btn_enter = 1'b0;
      repeat (20) @(negedge clk);
      check_idle("held_after_reset");

      // Commits at cursors 2 and 7.
      press(1'b0, 1'b1, 1'b0, 12, 12);
      press(1'b0, 1'b1, 1'b0, 12, 12);
      press(1'b0, 1'b0, 1'b1, 12, 12);
      for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0, 12, 12);
      press(1'b0, 1'b0, 1'b1, 12, 12);
      check_idle("commit_seq");

      // Aligned edges.
      press(1'b0, 1'b1, 1'b1, 15, 15);
      check_idle("right_enter");
      press(1'b1, 1'b1, 1'b0, 15, 15);
      check_idle("left_right");

      // Randomized mix.
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 5);
         case (k)
            0: press(1'b1, 1'b0, 1'b0, $urandom_range(10, 30), $urandom_range(10, 25));
            1: press(1'b0, 1'b1, 1'b0, $urandom_range(10, 30), $urandom_range(10, 25));
            2: press(1'b0, 1'b0, 1'b1, $urandom_range(10, 30), $urandom_range(10, 25));
            3: press(1'b1, 1'b1, 1'b0, $urandom_range(10, 30), $urandom_range(10, 25));
            4: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     $urandom_range(10, 30), $urandom_range(10, 25));
            default: glitch($urandom_range(0, 2), $urandom_range(1, DEB - 1));
         endcase
         check_idle("random");
      end

      w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("queue_drained", exp_q.size(), 0);
      check_idle("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
